// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg: shared width default, FSM state encoding and counter sizing for the serial adder.
package serial_add_ctrl_pkg;
    localparam int D_N_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ADD  = 2'd2,
        SEND = 2'd3
    } state_t;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int CNT_W = cnt_w(D_N_DEF);
endpackage

// File: rtl/serial_add_ctrl_adder_core.sv
// adder_core: combinational D_N-bit adder with carry-out.
module adder_core
    import serial_add_ctrl_pkg::*;
#(
    parameter int D_N = D_N_DEF
) (
    input  logic [D_N-1:0] a,
    input  logic [D_N-1:0] b,
    output logic [D_N-1:0] s,
    output logic           co
);
    assign {co, s} = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: loads two LSB-first serial operands, adds them, returns the sum serially and in parallel.
// Define SERIAL_ADD_CARRY_OUT_EN to append the carry-out as an extra final serial bit.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int D_N = D_N_DEF
) (
    input  logic           w_clk,
    input  logic           w_rst,
    input  logic           w_start,
    input  logic           w_a,
    input  logic           w_b,
    output logic           w_busy,
    output logic           w_dout,
    output logic           w_dvalid,
    output logic           w_done,
    output logic [D_N-1:0] w_sum
);
    localparam int CW = cnt_w(D_N);
`ifdef SERIAL_ADD_CARRY_OUT_EN
    localparam int SEND_LAST = D_N;
`else
    localparam int SEND_LAST = D_N - 1;
`endif

    state_t         state, state_nx;
    logic [CW-1:0]  cnt;
    logic [D_N-1:0] r_a, r_b, r_res, s;
    logic           co, fill, load_last, send_last;

    assign load_last = cnt == CW'(D_N - 1);
    assign send_last = cnt == CW'(SEND_LAST);

    adder_core #(.D_N(D_N)) u_adder_core (
        .a (r_a),
        .b (r_b),
        .s (s),
        .co(co)
    );

`ifdef SERIAL_ADD_CARRY_OUT_EN
    logic r_c;
    always_ff @(posedge w_clk) begin
        r_c <= w_rst ? 1'b0 : state == ADD ? co : state == SEND ? 1'b0 : r_c;
    end
    assign fill = r_c;
`else
    logic co_unused;
    assign co_unused = co;
    assign fill = 1'b0;
`endif

    always_ff @(posedge w_clk) begin
        state <= w_rst ? IDLE : state_nx;
    end

    always_comb begin
        state_nx = state;
        w_busy   = 1'b0;
        w_dvalid = 1'b0;
        w_dout   = 1'b0;
        state_nx = state == IDLE ? (w_start ? LOAD : IDLE) :
                   state == LOAD ? (load_last ? ADD : LOAD) :
                   state == ADD  ? SEND :
                   (send_last ? IDLE : SEND);
        w_busy   = state != IDLE;
        w_dvalid = state == SEND;
        w_dout   = w_dvalid & r_res[0];
    end

    // Datapath; the carry bit (when enabled) is shifted in behind the sum so it leaves last.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            cnt    <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            w_sum  <= '0;
            w_done <= 1'b0;
        end else begin
            w_done <= state == SEND && send_last;
            case (state)
                IDLE: if (w_start) begin
                    cnt <= '0;
                    r_a <= '0;
                    r_b <= '0;
                end
                LOAD: begin
                    r_a <= {w_a, r_a[D_N-1:1]};
                    r_b <= {w_b, r_b[D_N-1:1]};
                    cnt <= load_last ? '0 : cnt + 1'b1;
                end
                ADD: begin
                    r_res <= s;
                    w_sum <= s;
                    cnt   <= '0;
                end
                SEND: begin
                    r_res <= {fill, r_res[D_N-1:1]};
                    cnt   <= cnt + 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: randomized self-checking bench for serial_add_ctrl against an arithmetic reference.
module tb_serial_add_ctrl;
    localparam int N = 32;
`ifdef SERIAL_ADD_CARRY_OUT_EN
    localparam int EXP_N = N + 1;
`else
    localparam int EXP_N = N;
`endif

    logic w_clk = 1'b0, w_rst = 1'b0, w_start = 1'b0, w_a = 1'b0, w_b = 1'b0;
    logic w_busy, w_dout, w_dvalid, w_done;
    logic [N-1:0] w_sum;
    int n_cmp = 0, n_mis = 0;

    serial_add_ctrl #(.D_N(N)) dut (
        .w_clk   (w_clk),
        .w_rst   (w_rst),
        .w_start (w_start),
        .w_a     (w_a),
        .w_b     (w_b),
        .w_busy  (w_busy),
        .w_dout  (w_dout),
        .w_dvalid(w_dvalid),
        .w_done  (w_done),
        .w_sum   (w_sum)
    );

    always #5 w_clk = ~w_clk;

    task automatic tick;
        @(posedge w_clk);
        #1;
    endtask

    // Serial stream expected on w_dout, bit i = i-th emitted bit.
    function automatic logic [N:0] ref_serial(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N:0] t;
        t = {1'b0, a} + {1'b0, b};
        return (EXP_N > N) ? t : {1'b0, t[N-1:0]};
    endfunction

    task automatic load_operands(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input int s1, input int s2, output logic busy_after);
        w_start = 1'b1;
        tick;
        busy_after = w_busy;
        for (int i = 0; i < N; i++) begin
            w_a = a[i];
            w_b = b[i];
            w_start = (i == s1 || i == s2);
            tick;
        end
        w_start = 1'b0;
        w_a = 1'b0;
        w_b = 1'b0;
    endtask

    // Runs from the ADD cycle up to the w_done cycle (without stepping past it).
    task automatic collect(output logic [N:0] bits, output int nbits, output int done_cyc, output int bad_dout);
        bits = '0;
        nbits = 0;
        done_cyc = -1;
        bad_dout = 0;
        for (int c = 0; c <= N + 8; c++) begin
            tick;
            if (w_done) begin
                done_cyc = c;
                break;
            end
            if (w_dvalid) begin
                if (nbits <= N) bits[nbits] = w_dout;
                nbits++;
            end else if (w_dout) bad_dout++;
        end
    endtask

    task automatic test_reset;
        w_rst = 1'b1;
        tick;
        tick;
        w_rst = 1'b0;
        n_cmp++; if (w_busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b expected 0", w_busy); end
        n_cmp++; if (w_dvalid !== 1'b0) begin n_mis++; $display("FAIL reset_dvalid: got %b expected 0", w_dvalid); end
        n_cmp++; if (w_dout !== 1'b0) begin n_mis++; $display("FAIL reset_dout: got %b expected 0", w_dout); end
        n_cmp++; if (w_done !== 1'b0) begin n_mis++; $display("FAIL reset_done: got %b expected 0", w_done); end
        n_cmp++; if (w_sum !== '0) begin n_mis++; $display("FAIL reset_sum: got %h expected 0", w_sum); end
    endtask

    task automatic test_basic;
        logic [N:0] bits, exp;
        int nb, dc, bad;
        logic ba;
        exp = ref_serial(45, 34);
        load_operands(45, 34, -1, -1, ba);
        n_cmp++; if ({w_busy, w_dvalid} !== 2'b10) begin n_mis++; $display("FAIL basic_add_cycle: got busy/dvalid %b expected 10", {w_busy, w_dvalid}); end
        collect(bits, nb, dc, bad);
        n_cmp++; if (w_sum !== N'(79)) begin n_mis++; $display("FAIL basic_sum: got %0d expected 79", w_sum); end
        n_cmp++; if (bits !== exp) begin n_mis++; $display("FAIL basic_serial: got %h expected %h", bits, exp); end
        n_cmp++; if (nb !== EXP_N) begin n_mis++; $display("FAIL basic_nbits: got %0d expected %0d", nb, EXP_N); end
        n_cmp++; if (dc !== EXP_N) begin n_mis++; $display("FAIL basic_done_latency: got %0d expected %0d", dc, EXP_N); end
        n_cmp++; if ({w_busy, bad} !== {1'b0, 32'd0}) begin n_mis++; $display("FAIL basic_done_idle: got busy %b stray_dout %0d expected 0 0", w_busy, bad); end
        tick;
        n_cmp++; if (w_done !== 1'b0) begin n_mis++; $display("FAIL basic_done_pulse: got %b expected 0", w_done); end
    endtask

    task automatic test_carry;
        logic [N:0] bits, exp;
        int nb, dc, bad;
        logic ba;
        exp = ref_serial('1, 1);
        load_operands('1, 1, -1, -1, ba);
        collect(bits, nb, dc, bad);
        n_cmp++; if (w_sum !== '0) begin n_mis++; $display("FAIL carry_sum: got %h expected 0", w_sum); end
        n_cmp++; if (bits !== exp) begin n_mis++; $display("FAIL carry_serial: got %h expected %h", bits, exp); end
        n_cmp++; if (nb !== EXP_N) begin n_mis++; $display("FAIL carry_nbits: got %0d expected %0d", nb, EXP_N); end
    endtask

    task automatic test_start_ignored;
        logic [N:0] bits, exp;
        int nb, dc, bad;
        logic ba;
        exp = ref_serial(45, 34);
        load_operands(45, 34, 3, 10, ba);
        collect(bits, nb, dc, bad);
        n_cmp++; if (w_sum !== N'(79)) begin n_mis++; $display("FAIL ignore_sum: got %0d expected 79", w_sum); end
        n_cmp++; if (bits !== exp) begin n_mis++; $display("FAIL ignore_serial: got %h expected %h", bits, exp); end
        n_cmp++; if (dc !== EXP_N) begin n_mis++; $display("FAIL ignore_done: got %0d expected %0d", dc, EXP_N); end
        tick;
        n_cmp++; if (w_busy !== 1'b0) begin n_mis++; $display("FAIL ignore_no_queue: got busy %b expected 0", w_busy); end
    endtask

    task automatic test_random;
        logic [N-1:0] a, b;
        logic [N:0] bits, exp;
        int nb, dc, bad;
        logic ba;
        for (int t = 0; t < 8; t++) begin
            a = $urandom;
            b = $urandom;
            exp = ref_serial(a, b);
            repeat ($urandom_range(0, 3)) tick;
            load_operands(a, b, -1, -1, ba);
            collect(bits, nb, dc, bad);
            n_cmp++; if (w_sum !== a + b) begin n_mis++; $display("FAIL rand_sum[%0d]: got %h expected %h", t, w_sum, a + b); end
            n_cmp++; if ({bits, nb[7:0], dc[7:0]} !== {exp, 8'(EXP_N), 8'(EXP_N)}) begin
                n_mis++; $display("FAIL rand_serial[%0d]: got %h/%0d/%0d expected %h/%0d/%0d", t, bits, nb, dc, exp, EXP_N, EXP_N);
            end
        end
    endtask

    task automatic test_reset_mid_send;
        logic [N-1:0] a, b;
        logic [N:0] bits, exp;
        int nb, dc, bad, ndone;
        logic ba;
        load_operands(45, 34, -1, -1, ba);
        repeat (6) tick;
        w_rst = 1'b1;
        tick;
        w_rst = 1'b0;
        n_cmp++; if ({w_busy, w_dvalid, w_dout, w_done, w_sum} !== '0) begin
            n_mis++; $display("FAIL midrst_outputs: got busy %b dvalid %b dout %b done %b sum %h expected all 0", w_busy, w_dvalid, w_dout, w_done, w_sum);
        end
        ndone = 0;
        repeat (N + 4) begin tick; if (w_done || w_busy) ndone++; end
        n_cmp++; if (ndone !== 0) begin n_mis++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", ndone); end
        a = $urandom;
        b = $urandom;
        exp = ref_serial(a, b);
        load_operands(a, b, -1, -1, ba);
        collect(bits, nb, dc, bad);
        n_cmp++; if (w_sum !== a + b) begin n_mis++; $display("FAIL midrst_fresh_sum: got %h expected %h", w_sum, a + b); end
        n_cmp++; if (bits !== exp) begin n_mis++; $display("FAIL midrst_fresh_serial: got %h expected %h", bits, exp); end
    endtask

    task automatic test_back_to_back;
        logic [N-1:0] a, b;
        logic [N:0] bits, exp;
        int nb, dc, bad;
        logic ba;
        load_operands(7, 9, -1, -1, ba);
        collect(bits, nb, dc, bad);
        n_cmp++; if (w_sum !== N'(16)) begin n_mis++; $display("FAIL b2b_first_sum: got %0d expected 16", w_sum); end
        n_cmp++; if (dc !== EXP_N) begin n_mis++; $display("FAIL b2b_first_done: got %0d expected %0d", dc, EXP_N); end
        a = $urandom;
        b = $urandom;
        exp = ref_serial(a, b);
        load_operands(a, b, -1, -1, ba);
        n_cmp++; if (ba !== 1'b1) begin n_mis++; $display("FAIL b2b_busy_after_start: got %b expected 1", ba); end
        collect(bits, nb, dc, bad);
        n_cmp++; if (w_sum !== a + b) begin n_mis++; $display("FAIL b2b_second_sum: got %h expected %h", w_sum, a + b); end
        n_cmp++; if (bits !== exp) begin n_mis++; $display("FAIL b2b_second_serial: got %h expected %h", bits, exp); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_carry;
        test_start_ignored;
        test_random;
        test_reset_mid_send;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
